// File: rtl/data_rmw_adapter.sv
`default_nettype none
// ============================================================================
// Module      : data_rmw_adapter
// Description : Serialises core loads/stores into word-wide memory phases.
//               Sub-word stores become read-modify-write sequences.
//               Flags misaligned accesses and recovers from memory timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module data_rmw_adapter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_rd,
  input  logic        core_wr,
  input  logic [31:0] core_addr,
  input  logic [2:0]  core_len,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_halt,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Last value of the wait counter before a phase is abandoned.
  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_lane;      // byte offset of the access within the word
  logic        r_is_byte;   // sub-word store width: 1 = byte, 0 = half
  logic [15:0] r_wdata;     // right-justified sub-word store data
  logic        r_is_wr;
  logic [7:0]  r_wait;

  logic        w_req;
  logic        w_in_byte;
  logic        w_in_half;
  logic        w_in_word;
  logic        w_misalign;
  logic        w_ack;
  logic        w_timeout;
  logic [31:0] w_merged;

  assign w_req      = core_rd | core_wr;
  assign w_in_byte  = (core_len == 3'b001);
  assign w_in_half  = (core_len == 3'b010);
  // Any encoding other than byte/half is handled as a full word.
  assign w_in_word  = !w_in_byte && !w_in_half;
  assign w_misalign = (w_in_half && core_addr[0]) ||
                      (w_in_word && (core_addr[1:0] != 2'b00));
  // Acks outside an active phase are ignored.
  assign w_ack      = mem_ack && (mem_rd || mem_wr);
  assign w_timeout  = !w_ack && (r_wait == c_timeout_last);

  // Merge the store lane into the word just read from memory.
  always_comb begin
    w_merged = mem_rdata;
    if (r_is_byte) begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and the combinational stall to the core.
  always_comb begin
    w_next    = r_state;
    core_halt = 1'b0;
    case (r_state)
      S_IDLE: begin
        core_halt = w_req;
        if (w_req) begin
          if (w_misalign)                 w_next = S_DONE;
          else if (core_wr && w_in_word)  w_next = S_WR;
          else                            w_next = S_RD;
        end
      end
      S_RD: begin
        core_halt = 1'b1;
        if (w_ack)          w_next = r_is_wr ? S_WR : S_DONE;
        else if (w_timeout) w_next = S_DONE;
      end
      S_WR: begin
        core_halt = 1'b1;
        if (w_ack || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Registered memory-side outputs, request latch, wait counter and load data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lane     <= 2'b00;
      r_is_byte  <= 1'b0;
      r_wdata    <= 16'h0;
      r_is_wr    <= 1'b0;
      r_wait     <= 8'h0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      core_rdata <= 32'h0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_lane    <= core_addr[1:0];
            r_is_byte <= w_in_byte;
            r_wdata   <= core_wdata[15:0];
            r_is_wr   <= core_wr;
            r_wait    <= 8'h0;
            mem_addr  <= {core_addr[31:2], 2'b00};
            if (w_misalign) begin
              misalign   <= 1'b1;
              core_rdata <= 32'h0;
            end else if (core_wr && w_in_word) begin
              mem_wr    <= 1'b1;
              mem_wdata <= core_wdata;
            end else begin
              mem_rd <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (w_ack) begin
            mem_rd <= 1'b0;
            r_wait <= 8'h0;
            if (r_is_wr) begin
              mem_wr    <= 1'b1;
              mem_wdata <= w_merged;
            end else begin
              core_rdata <= mem_rdata;
            end
          end else if (w_timeout) begin
            mem_rd  <= 1'b0;
            bus_err <= 1'b1;
            if (!r_is_wr) core_rdata <= 32'h0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WR: begin
          if (w_ack) begin
            mem_wr <= 1'b0;
          end else if (w_timeout) begin
            mem_wr  <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_rmw_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_rmw_adapter
// Description : Scoreboard bench for data_rmw_adapter with a simple memory
//               model that acks after a programmable delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_rmw_adapter;

  localparam int K_RD = 0, K_WR = 1, K_MIS = 2, K_BERR = 3, K_RESP = 4;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_rd = 1'b0, core_wr = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [2:0]  core_len = 3'b100;
  logic [31:0] core_rdata;
  logic        core_halt, mem_rd, mem_wr, misalign, bus_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int  ack_delay = 1;
  bit  ack_enable = 1'b1;

  data_rmw_adapter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_len(core_len), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_halt(core_halt), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void exp_push(input int k, input logic [31:0] a,
                                   input logic [31:0] d, input bit c);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.chk = c;
    exp_q.push_back(e);
  endfunction

  task automatic got(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind=%0d addr=0x%08h data=0x%08h", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k <= K_WR && a !== e.addr) || (e.chk && d !== e.data)) begin
        errors++;
        $display("FAIL event: got kind=%0d addr=0x%08h data=0x%08h expected kind=%0d addr=0x%08h data=0x%08h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Memory model: acks the active phase in its ack_delay-th cycle.
  initial begin
    int wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if ((mem_rd || mem_wr) && ack_enable) begin
        if (wait_cnt + 1 >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (mem_rd) mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
          else        mem[mem_addr] = mem_wdata;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: turns DUT activity into events and checks them against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_rd && mem_wr) begin
        checks++; errors++;
        $display("FAIL rd_wr_overlap: got mem_rd=1 mem_wr=1 expected at most one");
      end
      if (misalign) got(K_MIS, 32'h0, 32'h0);
      if (bus_err)  got(K_BERR, 32'h0, 32'h0);
      if (mem_ack && mem_wr) got(K_WR, mem_addr, mem_wdata);
      if (mem_ack && mem_rd) got(K_RD, mem_addr, 32'h0);
      if ((core_rd || core_wr) && !core_halt) got(K_RESP, 32'h0, core_rdata);
    end
  end

  // Issue one core access and hold it until the stall is released.
  task automatic do_op(input bit wr, input logic [31:0] addr, input logic [2:0] len,
                       input logic [31:0] wd, input int dly,
                       output int hc, output int rc);
    bit done = 1'b0;
    hc = 0; rc = 0;
    ack_delay = dly;
    @(negedge clk);
    core_rd = !wr; core_wr = wr; core_addr = addr; core_len = len; core_wdata = wd;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (!core_halt) begin
        done = 1'b1;
      end else begin
        hc++;
        if (mem_rd) rc++;
        @(negedge clk);
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL op_timeout: got no halt release expected release within 100 cycles");
    end
    core_rd = 1'b0; core_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc, rc;
    bit seen;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("reset_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_core_rdata", core_rdata, 32'h0);
    chk("reset_core_halt", {31'h0, core_halt}, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word store: one write only.
    exp_push(K_WR, 32'h100, 32'h12345678, 1);
    exp_push(K_RESP, 0, 0, 0);
    do_op(1, 32'h100, 3'b100, 32'h12345678, 2, hc, rc);
    chk("wstore_halt_cycles", hc, 3);
    chk("wstore_rd_cycles", rc, 0);

    // Byte store RMW; upper data bits must not leak.
    mem[32'h100] = 32'h11223344;
    exp_push(K_RD, 32'h100, 0, 0);
    exp_push(K_WR, 32'h100, 32'h11AB3344, 1);
    exp_push(K_RESP, 0, 0, 0);
    do_op(1, 32'h102, 3'b001, 32'h777777AB, 1, hc, rc);
    chk("bstore_halt_cycles", hc, 3);

    // Back-to-back half stores into the same word.
    mem[32'h200] = 32'hAAAAAAAA;
    exp_push(K_RD, 32'h200, 0, 0);
    exp_push(K_WR, 32'h200, 32'hBEEFAAAA, 1);
    exp_push(K_RESP, 0, 0, 0);
    do_op(1, 32'h202, 3'b010, 32'h5555BEEF, 1, hc, rc);
    exp_push(K_RD, 32'h200, 0, 0);
    exp_push(K_WR, 32'h200, 32'hBEEF1234, 1);
    exp_push(K_RESP, 0, 0, 0);
    do_op(1, 32'h200, 3'b010, 32'h00001234, 2, hc, rc);
    chk("hstore2_halt_cycles", hc, 5);

    // Misaligned half load and word store, plus illegal length treated as word.
    exp_push(K_MIS, 0, 0, 0);
    exp_push(K_RESP, 0, 32'h0, 1);
    do_op(0, 32'h203, 3'b010, 32'h0, 1, hc, rc);
    chk("mis_hload_halt_cycles", hc, 1);
    exp_push(K_MIS, 0, 0, 0);
    exp_push(K_RESP, 0, 0, 0);
    do_op(1, 32'h106, 3'b100, 32'hFFFFFFFF, 1, hc, rc);
    chk("mis_wstore_halt_cycles", hc, 1);
    exp_push(K_MIS, 0, 0, 0);
    exp_push(K_RESP, 0, 32'h0, 1);
    do_op(0, 32'h102, 3'b000, 32'h0, 1, hc, rc);

    // Loads: word load and an aligned byte load at the top lane.
    mem[32'h304] = 32'hCAFEF00D;
    exp_push(K_RD, 32'h304, 0, 0);
    exp_push(K_RESP, 0, 32'hCAFEF00D, 1);
    do_op(0, 32'h304, 3'b100, 32'h0, 1, hc, rc);
    chk("load_halt_cycles", hc, 2);
    exp_push(K_RD, 32'h200, 0, 0);
    exp_push(K_RESP, 0, 32'hBEEF1234, 1);
    do_op(0, 32'h203, 3'b001, 32'h0, 3, hc, rc);
    chk("bload_halt_cycles", hc, 4);

    // Timeout on a load: 16 wait cycles, then bus_err and zero data.
    ack_enable = 1'b0;
    exp_push(K_BERR, 0, 0, 0);
    exp_push(K_RESP, 0, 32'h0, 1);
    do_op(0, 32'h400, 3'b100, 32'h0, 1, hc, rc);
    chk("timeout_rd_cycles", rc, 16);
    chk("timeout_halt_cycles", hc, 17);
    ack_enable = 1'b1;

    // Reset during the WR phase of a byte store.
    mem[32'h600] = 32'h01020304;
    ack_delay = 4;
    exp_push(K_RD, 32'h600, 0, 0);
    @(negedge clk);
    core_wr = 1'b1; core_addr = 32'h601; core_len = 3'b001; core_wdata = 32'hCC;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mem_wr) seen = 1'b1;
    end
    chk("rmw_reached_wr", {31'h0, seen}, 32'h1);
    @(negedge clk);
    #3;
    core_wr = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("arst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_mem_wdata", mem_wdata, 32'h0);
    chk("arst_core_rdata", core_rdata, 32'h0);
    chk("arst_flags", {30'h0, misalign, bus_err}, 32'h0);
    chk("arst_core_halt", {31'h0, core_halt}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("abandoned_store_mem", mem[32'h600], 32'h01020304);

    exp_push(K_WR, 32'h500, 32'hDEADBEEF, 1);
    exp_push(K_RESP, 0, 0, 0);
    do_op(1, 32'h500, 3'b100, 32'hDEADBEEF, 1, hc, rc);
    chk("post_reset_wstore_halt", hc, 2);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_rmw_adapter.md
# data_rmw_adapter

Sits between the core's data port and the Controller's data-memory port. It serialises each core load/store into word-wide memory transactions and stalls the core through its halt input until the transaction completes. Byte and halfword stores become read-modify-write sequences, because the data-memory port only accepts full 32-bit writes. The block also detects misaligned accesses and recovers from memory timeouts.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles to wait for `mem_ack` per memory phase; range 1–255.
- `clk` input, 1: system clock; all logic is on the rising edge.
- `reset_n` input, 1: asynchronous, active-low reset.
- `core_rd` input, 1: load request; held by the core while `core_halt` is 1.
- `core_wr` input, 1: store request; held by the core while `core_halt` is 1.
- `core_addr` input, 32: byte address.
- `core_len` input, 3: access size, one-hot; `001` byte, `010` half, `100` word. Any other value is treated as word.
- `core_wdata` input, 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `core_rdata` output, 32: aligned memory word for loads. The core extracts the lane itself.
- `core_halt` output, 1: stall to the core.
- `mem_rd` output, 1: word read request to the Controller.
- `mem_wr` output, 1: word write request to the Controller.
- `mem_addr` output, 32: `{core_addr[31:2], 2'b00}`.
- `mem_wdata` output, 32: full word to write.
- `mem_rdata` input, 32: read data; valid in the cycle `mem_ack` is 1.
- `mem_ack` input, 1: one-cycle completion pulse for the current `mem_rd`/`mem_wr`.
- `misalign` output, 1: one-cycle pulse when an access is rejected as misaligned.
- `bus_err` output, 1: one-cycle pulse when a memory phase times out.

## Operation
- **FSM states:** IDLE, RD, WR, DONE.
- **IDLE, no request:** `core_halt` = 0.
- **IDLE, request accepted** (`core_rd | core_wr`; `core_wr` wins if both are 1):
  - Latch addr, len, wdata and the op.
  - `core_halt` is combinationally 1 in this same cycle.
- **Misalignment check in IDLE:**
  - Half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0, is misaligned.
  - Misaligned access: go to DONE. No memory access, `misalign` = 1 for that cycle, `core_rdata` = 0.
- **Aligned load or sub-word store:** go to RD.
- **Aligned word store:** go to WR with `mem_wdata` = `core_wdata`.
- **RD:**
  - `mem_rd` = 1 and held until `mem_ack`.
  - On ack: capture `mem_rdata` into the data register.
  - Load: go to DONE.
  - Store: merge the lane and go to WR.
    - Byte: replace bits [8k+7:8k], k = `addr[1:0]`.
    - Half: replace bits [16h+15:16h], h = `addr[1]`.
- **WR:** `mem_wr` = 1 with the merged word, held until `mem_ack`; then go to DONE.
- **DONE:**
  - `core_halt` = 0 for exactly one cycle.
  - `core_rdata` = data register (valid this cycle and held until the next load completes).
  - Next state is always IDLE; a request present on the next cycle is treated as new.
- **Timeout:**
  - A wait counter clears on entry to RD/WR and increments each cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`: drop `mem_rd`/`mem_wr`, pulse `bus_err`, go to DONE.
  - Load data is 0; a pending store write is abandoned.
- **Request shape:** `mem_rd` and `mem_wr` are never both 1. At most one memory phase is outstanding.
- **Reset:** asynchronous `reset_n` = 0 takes effect immediately, including mid-RMW.
  - FSM goes to IDLE.
  - `mem_rd`, `mem_wr`, `misalign`, `bus_err` = 0.
  - `mem_addr`, `mem_wdata`, `core_rdata`, counter = 0.
  - `core_halt` = 0 (no request is latched).

## Timing
- All memory-side outputs are registered. `core_halt` is combinational from IDLE and the core request inputs.
- Aligned load, ack N cycles after `mem_rd` rises (N ≥ 1): core stalled 1 + N cycles, `core_rdata` valid in the DONE cycle. Minimum request-to-release is 3 cycles.
- Word store: same as a load, with one WR phase.
- Sub-word store: RD phase then WR phase; minimum 4 cycles from accept to the DONE cycle.
- Misaligned access: IDLE → DONE; one halt cycle.
- A `mem_ack` arriving while neither `mem_rd` nor `mem_wr` is 1 is ignored.

## Test plan
- **Word store:** 0x12345678 to 0x100, ack 2 cycles after `mem_wr` → exactly one write, `mem_addr` = 0x100, `mem_wdata` = 0x12345678, no `mem_rd`, `core_halt` drops in DONE.
- **Byte store:** 0xAB to 0x102, memory word 0x11223344 → read 0x100, then write 0x11AB3344.
- **Half store:** 0xBEEF to 0x202, memory 0xAAAAAAAA → write 0xBEEFAAAA. A second back-to-back half store 0x1234 to 0x200 → 0xBEEF1234.
- **Load:** from 0x304, ack returns 0xCAFEF00D → `core_rdata` = 0xCAFEF00D in the DONE cycle, halt released once.
- **Misaligned:** half load at 0x203 and word store at 0x106 → no `mem_rd`/`mem_wr`, one `misalign` pulse each, one halt cycle each.
- **Timeout and reset:**
  - `TIMEOUT_CYCLES` = 16, ack never arrives on a load → `bus_err` after 16 wait cycles, `core_rdata` = 0.
  - Then `reset_n` pulsed low during the WR phase of a byte store → all outputs 0 immediately, FSM in IDLE, and the next word store completes normally.
